// File: rtl/tone_pkg.sv
// Shared types and note tables for the tone beep driver: FSM state, note codes,
// note frequencies and the half-period constant function.
package tone_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned DUR_W  = 12;
  localparam int unsigned HALF_W = 17;
  localparam int unsigned MS_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } tone_state_e;

  localparam logic [CODE_W-1:0] REST = 5'd0;
  localparam logic [CODE_W-1:0] C4 = 5'd1,  D4 = 5'd2,  E4 = 5'd3,  F4 = 5'd4;
  localparam logic [CODE_W-1:0] G4 = 5'd5,  A4 = 5'd6,  B4 = 5'd7;
  localparam logic [CODE_W-1:0] C5 = 5'd8,  D5 = 5'd9,  E5 = 5'd10, F5 = 5'd11;
  localparam logic [CODE_W-1:0] G5 = 5'd12, A5 = 5'd13, B5 = 5'd14;
  localparam logic [CODE_W-1:0] C6 = 5'd15, D6 = 5'd16, E6 = 5'd17, F6 = 5'd18;
  localparam logic [CODE_W-1:0] G6 = 5'd19, A6 = 5'd20, B6 = 5'd21;

  // Equal-tempered pitches rounded to whole Hz; every other code is a rest.
  function automatic int unsigned note_freq_hz(logic [CODE_W-1:0] code);
    case (code)
      C4: return 262;   D4: return 294;   E4: return 330;   F4: return 349;
      G4: return 392;   A4: return 440;   B4: return 494;
      C5: return 523;   D5: return 587;   E5: return 659;   F5: return 698;
      G5: return 784;   A5: return 880;   B5: return 988;
      C6: return 1047;  D6: return 1175;  E6: return 1319;  F6: return 1397;
      G6: return 1568;  A6: return 1760;  B6: return 1976;
      default: return 0;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] note_half_period(int unsigned clk_freq,
                                                         logic [CODE_W-1:0] code);
    int unsigned freq;
    freq = note_freq_hz(code);
    if (freq == 0) return '0;
    return HALF_W'(clk_freq / (2 * freq));
  endfunction

  function automatic logic note_is_rest(logic [CODE_W-1:0] code);
    return note_freq_hz(code) == 0;
  endfunction

endpackage

// File: rtl/tone_note_rom.sv
// Registered note-code to half-period lookup, one cycle of latency; rests read 0.
module tone_note_rom
  import tone_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CODE_W-1:0] code,
  output logic [HALF_W-1:0] half_period
);

  logic [HALF_W-1:0] rom_c [2**CODE_W];

  for (genvar i = 0; i < 2**CODE_W; i++) begin : g_rom
    assign rom_c[i] = note_half_period(CLK_FREQ, CODE_W'(i));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) half_period <= '0;
    else         half_period <= rom_c[code];
  end

endmodule

// File: rtl/tone_beep_driver.sv
// Plays one note per request as a square wave on beep, then an optional silent gap
// and a one-cycle done pulse. Define TONE_BEEP_ABORT_EN to add the note_abort input.
module tone_beep_driver
  import tone_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned MS_CYCLES = 50_000,
  parameter int unsigned GAP_MS    = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [CODE_W-1:0] note_code,
  input  logic [DUR_W-1:0]  dur_ms,
  output logic              beep,
  output logic              busy,
`ifdef TONE_BEEP_ABORT_EN
  input  logic              note_abort,
`endif
  output logic              done
);

  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);
  localparam bit               HAS_GAP  = (GAP_MS != 0);

  tone_state_e       state_q, state_d;
  logic [CODE_W-1:0] code_q;
  logic [DUR_W-1:0]  dur_q;
  logic              rest_q;
  logic [HALF_W-1:0] half_period;
  logic [HALF_W-1:0] tone_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [DUR_W-1:0]  dur_cnt;
  logic              accept_c, abort_c, ms_wrap_c, play_last_c, gap_last_c, tone_wrap_c;
  logic              beep_d, busy_d, done_d;

  assign note_ready  = (state_q == IDLE);
  assign accept_c    = note_valid && note_ready;
  assign ms_wrap_c   = (ms_cnt == MS_LAST);
  assign play_last_c = ms_wrap_c && (dur_cnt == dur_q - DUR_W'(1));
  assign gap_last_c  = ms_wrap_c && (dur_cnt == GAP_LAST);
  assign tone_wrap_c = (half_period != '0) && (tone_cnt == half_period - HALF_W'(1));

`ifdef TONE_BEEP_ABORT_EN
  assign abort_c = note_abort && (state_q != IDLE);
`else
  assign abort_c = 1'b0;
`endif

  tone_note_rom #(
    .CLK_FREQ (CLK_FREQ)
  ) u_rom (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .code        (code_q),
    .half_period (half_period)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Abort overrides every normal transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = LOAD;
      LOAD:    if (dur_q == '0) state_d = HAS_GAP ? GAP : IDLE;
               else             state_d = PLAY;
      PLAY:    if (play_last_c) state_d = HAS_GAP ? GAP : IDLE;
      GAP:     if (gap_last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_c) state_d = IDLE;
  end

  // Leaving PLAY for any reason forces beep low, even on a toggle cycle.
  always_comb begin
    beep_d = 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == IDLE) && (state_q != IDLE);
    if (state_d == PLAY) begin
      if (state_q == LOAD)               beep_d = ~rest_q;
      else if (tone_wrap_c && !rest_q)   beep_d = ~beep;
      else                               beep_d = beep;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      beep <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      beep <= beep_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

  // ms_cnt/dur_cnt are shared by PLAY and GAP and restart on every state change.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      code_q   <= '0;
      dur_q    <= '0;
      rest_q   <= 1'b0;
      tone_cnt <= '0;
      ms_cnt   <= '0;
      dur_cnt  <= '0;
    end else begin
      if (accept_c) begin
        code_q <= note_code;
        dur_q  <= dur_ms;
        rest_q <= note_is_rest(note_code);
      end

      if (state_q != PLAY || state_d != PLAY || tone_wrap_c || half_period == '0)
        tone_cnt <= '0;
      else
        tone_cnt <= tone_cnt + HALF_W'(1);

      if (state_d != state_q || state_q == IDLE || state_q == LOAD) begin
        ms_cnt  <= '0;
        dur_cnt <= '0;
      end else if (ms_wrap_c) begin
        ms_cnt  <= '0;
        dur_cnt <= dur_cnt + DUR_W'(1);
      end else begin
        ms_cnt  <= ms_cnt + MS_W'(1);
      end
    end
  end

endmodule
